// File: rtl/alu_result_sel_pipe_if.sv
// alu_result_sel_pipe_if: producer / writeback facing bus of alu_result_sel_pipe.
// master = the side that drives results and consumes the output (producer +
// writeback), slave = the selector pipe itself. The out_zero / out_neg wires
// exist only when ALU_SEL_FLAGS_EN is defined.
interface alu_result_sel_pipe_if #(
    parameter int WIDTH     = 24,
    parameter int NUM_IN    = 8,
    parameter int SEL_W     = 3,
    parameter int ERR_CNT_W = 8
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_err;
    logic [ERR_CNT_W-1:0]    err_cnt;
`ifdef ALU_SEL_FLAGS_EN
    logic                    out_zero;
    logic                    out_neg;
`endif

    modport master (
        output in_bus, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_err, err_cnt
`ifdef ALU_SEL_FLAGS_EN
        , input out_zero, out_neg
`endif
    );

    modport slave (
        input  in_bus, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_err, err_cnt
`ifdef ALU_SEL_FLAGS_EN
        , output out_zero, out_neg
`endif
    );
endinterface

// File: rtl/alu_result_sel_pipe.sv
// alu_result_sel_pipe: registered NUM_IN:1 ALU result selector with a 2-entry
// skid buffer (output register + skid register) on a valid/ready handshake.
// Illegal selects return DEFAULT_VAL, flag out_err and bump a saturating counter.
// Optional feature macro: ALU_SEL_FLAGS_EN adds out_zero / out_neg, computed at
// capture and carried with their beat through the skid.
module alu_result_sel_pipe #(
    parameter int               WIDTH       = 24,
    parameter int               NUM_IN      = 8,
    parameter int               SEL_W       = 3,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter int               ERR_CNT_W   = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    alu_result_sel_pipe_if.slave bus
);

    // One stored beat: data plus everything that must travel with it.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
`ifdef ALU_SEL_FLAGS_EN
        logic             zero;
        logic             neg;
`endif
    } beat_t;

    // Encoding is {out_valid, skid_full}.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_FULL  = 2'b11
    } state_t;

    state_t               state_q, state_d;
    beat_t                out_q, out_d;
    beat_t                skid_q, skid_d;
    beat_t                cap_beat;
    logic                 in_ready_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 accept, consume;

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = (state_q != S_EMPTY) & bus.out_ready;

    // Build the beat for the current select, including its flags.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        cap_beat      = '0;
        cap_beat.data = DEFAULT_VAL;
        cap_beat.err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                cap_beat.data = bus.in_bus[k*WIDTH +: WIDTH];
                cap_beat.err  = 1'b0;
            end
        end
`ifdef ALU_SEL_FLAGS_EN
        cap_beat.zero = (cap_beat.data == '0);
        cap_beat.neg  = cap_beat.data[WIDTH-1];
`endif
    end

    // Storage state register plus registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    // Next storage state from accept / consume.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: if (accept) state_d = S_ONE;
            S_ONE: begin
                if (accept && !consume)      state_d = S_FULL;
                else if (consume && !accept) state_d = S_EMPTY;
            end
            S_FULL:  if (consume) state_d = S_ONE;
            default: state_d = S_EMPTY;
        endcase
    end

    // Datapath moves: new beat to output, new beat to skid, or skid to output.
    always_comb begin
        out_d     = out_q;
        skid_d    = skid_q;
        err_cnt_d = err_cnt_q;
        if (state_q == S_FULL && consume) begin
            out_d = skid_q;
        end else if (accept && (state_q == S_EMPTY || consume)) begin
            out_d = cap_beat;
        end else if (accept) begin
            skid_d = cap_beat;
        end
        if (accept && cap_beat.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Data registers and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the skid register is reset too, so no stale beat can ever surface.
            out_q     <= '0;
            skid_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            out_q     <= out_d;
            skid_q    <= skid_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.out_data  = out_q.data;
    assign bus.out_err   = out_q.err;
    assign bus.err_cnt   = err_cnt_q;
`ifdef ALU_SEL_FLAGS_EN
    assign bus.out_zero  = out_q.zero;
    assign bus.out_neg   = out_q.neg;
`endif

endmodule
